seg595_scan: RTL and testbench

- Downstream consumer of the key/parameter stage's 24-bit `disp_data` output: six 4-bit hex digits, digit 0 = `disp_data[3:0]`, rightmost.
- Time-multiplexes the six digits of a common-anode 7-segment display.
- Serialises one 14-bit frame per digit into two daisy-chained 74HC595s: 6 digit-select bits followed by 8 segment bits.
- Drives the 595 pins SHCP, STCP, DS and OE_n directly.

---
 rtl/seg595_scan.sv | 185 ++++++++++++++++++
 tb/tb_seg595_scan.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg595_scan.sv
// Six-digit common-anode display scanner: one {sel,seg} frame per scan tick into two chained 74HC595s.
// Frame is 1 + 30*CLK_DIV cycles from tick to STCP fall; no handshakes, inputs are sampled once per sweep.
module seg595_scan #(
  parameter int CLK_DIV  = 2,
  parameter int SCAN_CNT = 49_999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] disp_data,
  input  logic [5:0]  dot,
  input  logic        blank_en,
  output logic        shcp,
  output logic        stcp,
  output logic        ds,
  output logic        oe_n
);

  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int SW = $clog2(SCAN_CNT + 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CNT);

  typedef enum logic [1:0] {S_WAIT, S_LOAD, S_SHIFT, S_LATCH} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_scan;
  logic [2:0]      r_digit;
  logic            r_first;
  logic [23:0]     r_data;
  logic [5:0]      r_dot;
  logic            r_blank;
  logic [13:0]     r_frame;
  logic [3:0]      r_bit;
  logic [DW-1:0]   r_div;
  logic            r_shcp;
  logic            r_stcp;
  logic            r_ds;
  logic            r_oe_n;

  logic            w_tick;
  logic [2:0]      w_dig_nxt;
  logic            w_snap;
  logic [23:0]     w_data;
  logic [5:0]      w_dots;
  logic            w_blank;
  logic [23:0]     w_upper;
  logic [5:0]      w_dots_up;
  logic            w_lead;
  logic [7:0]      w_seg;
  logic [5:0]      w_sel;

  function automatic logic [7:0] seg_lut(input logic [3:0] n);
    case (n)
      4'h0: seg_lut = 8'hC0;
      4'h1: seg_lut = 8'hF9;
      4'h2: seg_lut = 8'hA4;
      4'h3: seg_lut = 8'hB0;
      4'h4: seg_lut = 8'h99;
      4'h5: seg_lut = 8'h92;
      4'h6: seg_lut = 8'h82;
      4'h7: seg_lut = 8'hF8;
      4'h8: seg_lut = 8'h80;
      4'h9: seg_lut = 8'h90;
      4'hA: seg_lut = 8'h88;
      4'hB: seg_lut = 8'h83;
      4'hC: seg_lut = 8'hC6;
      4'hD: seg_lut = 8'hA1;
      4'hE: seg_lut = 8'h86;
      default: seg_lut = 8'h8E;
    endcase
  endfunction

  assign w_tick = (r_scan == SCAN_LAST);

  // Digit 0 frames build from the live inputs, which also become the sweep snapshot.
  assign w_dig_nxt = r_first ? 3'd0 : ((r_digit == 3'd5) ? 3'd0 : r_digit + 3'd1);
  assign w_snap    = (w_dig_nxt == 3'd0);
  assign w_data    = w_snap ? disp_data : r_data;
  assign w_dots    = w_snap ? dot : r_dot;
  assign w_blank   = w_snap ? blank_en : r_blank;
  assign w_upper   = w_data >> {w_dig_nxt, 2'b00};
  assign w_dots_up = w_dots >> w_dig_nxt;
  // A lit DP on this or any higher digit ends the leading-zero run.
  assign w_lead    = w_blank && (w_dig_nxt != 3'd0) && (w_upper == 24'd0) && (w_dots_up == 6'd0);
  assign w_seg     = w_lead ? 8'hFF : (seg_lut(w_upper[3:0]) & {~w_dots_up[0], 7'h7F});
  assign w_sel     = 6'b000001 << w_dig_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scan <= '0;
    end else if (w_tick) begin
      r_scan <= '0;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT:  if (w_tick) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_div == DIV_LAST && r_bit == 4'd0) w_state_nxt = S_LATCH;
      S_LATCH: if (r_div == DIV_LAST) w_state_nxt = S_WAIT;
      default: w_state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digit <= 3'd0;
      r_first <= 1'b1;
      r_data  <= '0;
      r_dot   <= '0;
      r_blank <= 1'b0;
      r_frame <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_shcp  <= 1'b0;
      r_stcp  <= 1'b0;
      r_ds    <= 1'b0;
      r_oe_n  <= 1'b1;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_digit <= w_dig_nxt;
          r_first <= 1'b0;
          if (w_snap) begin
            r_data  <= disp_data;
            r_dot   <= dot;
            r_blank <= blank_en;
          end
          r_frame <= {w_sel, w_seg};
          r_bit   <= 4'd13;
          r_div   <= '0;
        end
        S_SHIFT: begin
          if (r_div == '0) begin
            r_ds   <= r_frame[r_bit];
            r_shcp <= 1'b0;
          end
          if (r_div == DIV_HALF) r_shcp <= 1'b1;
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (r_bit != 4'd0) r_bit <= r_bit - 4'd1;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_LATCH: begin
          // Divider 0 closes the last SHCP high phase; STCP follows in the second half.
          if (r_div == '0) r_shcp <= 1'b0;
          if (r_div == DIV_PRE) begin
            r_stcp <= 1'b1;
            r_oe_n <= 1'b0;
          end
          if (r_div == DIV_LAST) begin
            r_stcp <= 1'b0;
            r_div  <= '0;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign shcp = r_shcp;
  assign stcp = r_stcp;
  assign ds   = r_ds;
  assign oe_n = r_oe_n;

endmodule

// File: tb/tb_seg595_scan.sv
// Bench for seg595_scan: a serial-frame monitor checked against a digit-level display model,
// plus directed sweeps with hand-computed frames.
module tb_seg595_scan;

  localparam int CLK_DIV  = 2;
  localparam int SCAN_CNT = 99;

  logic        clk;
  logic        reset_n;
  logic [23:0] disp_data;
  logic [5:0]  dot;
  logic        blank_en;
  logic        shcp;
  logic        stcp;
  logic        ds;
  logic        oe_n;

  seg595_scan #(.CLK_DIV(CLK_DIV), .SCAN_CNT(SCAN_CNT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .disp_data (disp_data),
    .dot       (dot),
    .blank_en  (blank_en),
    .shcp      (shcp),
    .stcp      (stcp),
    .ds        (ds),
    .oe_n      (oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [13:0] model_frame(input logic [23:0] d, input logic [5:0] dp,
                                              input logic bl, input int k);
    logic [23:0] up;
    logic [5:0]  dup;
    logic [5:0]  sel;
    logic [7:0]  seg;
    up  = d >> (4 * k);
    dup = dp >> k;
    sel = '0;
    sel[k] = 1'b1;
    if (bl && k > 0 && up == 24'd0 && dup == 6'd0) begin
      seg = 8'hFF;
    end else begin
      seg = seg_tab[up[3:0]];
      if (dup[0]) seg[7] = 1'b0;
    end
    return {sel, seg};
  endfunction

  // Monitor state: everything the serial lines reveal, plus the model's sweep position.
  int          edge_cnt = 0;
  int          frame_cnt = 0;
  int          model_dig = 0;
  int          ds_age = 0;
  int          hold = 0;
  int          stcp_hi = 0;
  logic [13:0] sh = '0;
  logic        prev_shcp = 1'b0;
  logic        prev_stcp = 1'b0;
  logic        prev_ds = 1'b0;
  logic        held_ds = 1'b0;
  logic        seen_stcp = 1'b0;
  logic [23:0] m_data = '0;
  logic [5:0]  m_dot = '0;
  logic        m_blank = 1'b0;
  logic [13:0] frames [64];

  always @(negedge clk) begin
    if (!reset_n) begin
      edge_cnt  = 0;
      model_dig = 0;
      ds_age    = 0;
      hold      = 0;
      stcp_hi   = 0;
      sh        = '0;
      prev_shcp = 1'b0;
      prev_stcp = 1'b0;
      prev_ds   = 1'b0;
      seen_stcp = 1'b0;
    end else begin
      chk("overlap", {31'd0, shcp & stcp}, 32'd0);
      if (hold > 0) begin
        chk("ds_hold", {31'd0, ds}, {31'd0, held_ds});
        hold--;
      end
      if (ds !== prev_ds) ds_age = 0;
      else ds_age++;
      if (shcp && !prev_shcp) begin
        chk("ds_setup", {31'd0, ds_age >= CLK_DIV}, 32'd1);
        if (edge_cnt == 0 && model_dig == 0) begin
          m_data  = disp_data;
          m_dot   = dot;
          m_blank = blank_en;
        end
        sh       = {sh[12:0], ds};
        edge_cnt++;
        hold     = CLK_DIV - 1;
        held_ds  = ds;
      end
      if (stcp && !prev_stcp) begin
        seen_stcp = 1'b1;
        chk("edge_count", edge_cnt, 32'd14);
        chk("frame", {18'd0, sh}, {18'd0, model_frame(m_data, m_dot, m_blank, model_dig)});
        if (frame_cnt < 64) frames[frame_cnt] = sh;
        frame_cnt++;
        model_dig = (model_dig + 1) % 6;
        edge_cnt  = 0;
        stcp_hi   = 0;
      end
      if (stcp) stcp_hi++;
      if (!stcp && prev_stcp) chk("stcp_width", stcp_hi, CLK_DIV);
      chk("oe_n", {31'd0, oe_n}, {31'd0, ~seen_stcp});
      prev_shcp = shcp;
      prev_stcp = stcp;
      prev_ds   = ds;
    end
  end

  task automatic wait_frames(input int n);
    int budget;
    budget = 0;
    while (frame_cnt < n && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (frame_cnt < n) chk("frame_timeout", frame_cnt, n);
  endtask

  task automatic wait_edges(input int n);
    int budget;
    budget = 0;
    while (edge_cnt < n && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (edge_cnt < n) chk("edge_timeout", edge_cnt, n);
  endtask

  logic [13:0] exp_sweep1 [7] = '{14'h0182, 14'h0292, 14'h0499, 14'h08B0, 14'h10A4, 14'h20F9, 14'h0182};
  logic [13:0] exp_blank  [6] = '{14'h01C0, 14'h02A4, 14'h04F9, 14'h08FF, 14'h10FF, 14'h20FF};
  logic [13:0] exp_dot    [6] = '{14'h01C0, 14'h02C0, 14'h0440, 14'h08FF, 14'h10FF, 14'h20FF};

  initial begin
    reset_n   = 1'b0;
    disp_data = 24'h123456;
    dot       = 6'b000000;
    blank_en  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_shcp", {31'd0, shcp}, 32'd0);
    chk("rst_stcp", {31'd0, stcp}, 32'd0);
    chk("rst_ds",   {31'd0, ds},   32'd0);
    chk("rst_oe_n", {31'd0, oe_n}, 32'd1);
    reset_n = 1'b1;

    wait_frames(7);
    for (int i = 0; i < 7; i++) chk($sformatf("sweep1_f%0d", i), {18'd0, frames[i]}, {18'd0, exp_sweep1[i]});

    wait_frames(12);
    disp_data = 24'h000120;
    blank_en  = 1'b1;
    wait_frames(18);
    for (int i = 0; i < 6; i++) chk($sformatf("blank_f%0d", i), {18'd0, frames[12 + i]}, {18'd0, exp_blank[i]});

    disp_data = 24'h000000;
    dot       = 6'b000100;
    wait_frames(24);
    for (int i = 0; i < 6; i++) chk($sformatf("dot_f%0d", i), {18'd0, frames[18 + i]}, {18'd0, exp_dot[i]});

    disp_data = 24'h123456;
    dot       = 6'b000000;
    blank_en  = 1'b0;
    wait_frames(27);
    wait_edges(1);
    disp_data = 24'hFFFFFF;
    wait_frames(31);
    chk("tear_d4", {18'd0, frames[28]}, 32'h10A4);
    chk("tear_d5", {18'd0, frames[29]}, 32'h20F9);
    chk("tear_d0", {18'd0, frames[30]}, 32'h018E);

    wait_edges(7);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_shcp", {31'd0, shcp}, 32'd0);
    chk("midrst_stcp", {31'd0, stcp}, 32'd0);
    chk("midrst_ds",   {31'd0, ds},   32'd0);
    chk("midrst_oe_n", {31'd0, oe_n}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_frames(32);
    chk("postrst_d0", {18'd0, frames[31]}, 32'h018E);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
